// File: rtl/enigma_stream_feeder.sv
// enigma_stream_feeder: front end of the enigma core.
// Host ASCII bytes are buffered in a FIFO. Each letter goes through the core
// one at a time. Every other byte bypasses the core. All results leave in the
// original stream order.
// Optional build macro LOWERCASE_FOLD_EN: when it is defined, lowercase letters
// are folded to uppercase and sent through the core. When it is undefined,
// lowercase bytes pass through unchanged like punctuation.
module enigma_stream_feeder #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        core_valid,
    output logic [7:0]  core_din,
    input  logic        core_done,
    input  logic [7:0]  core_dout,
    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] letter_count,
    output logic        timeout_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  TIMEOUT_CHAR = 8'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    // The byte popped from the FIFO is held in one of two places. A letter is
    // held in core_din_q, which drives the core. A bypass byte goes straight
    // into m_data_q. Because of this, no separate hold register is needed.
    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] letter_count_q, letter_count_d;
    logic        timeout_err_q, timeout_err_d;
    logic        core_valid_q, core_valid_d;
    logic [7:0]  core_din_q, core_din_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q, m_data_d;

    logic [7:0]  fifo_mem [DEPTH];
    logic        fifo_empty;
    logic        fifo_full;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  head_byte;

    // Returns 1 for bytes that must go through the core.
    function automatic logic is_letter(input logic [7:0] b);
`ifdef LOWERCASE_FOLD_EN
        return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
`else
        return (b >= 8'h41) && (b <= 8'h5A);
`endif
    endfunction

    // Maps a letter to the uppercase form that the core expects.
    function automatic logic [7:0] core_letter(input logic [7:0] b);
`ifdef LOWERCASE_FOLD_EN
        return ((b >= 8'h61) && (b <= 8'h7A)) ? (b - 8'h20) : b;
`else
        return b;
`endif
    endfunction

    // Each pointer has one extra wrap bit. Equal pointers mean the FIFO is
    // empty. If only the wrap bits differ, the FIFO is full. When the FIFO is
    // full, a write must wait for a pop in an earlier cycle.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign s_ready    = !fifo_full;
    assign wr_en      = s_valid && !fifo_full;
    assign rd_en      = (state_q == IDLE) && !fifo_empty;
    assign head_byte  = fifo_mem[rd_ptr_q[AW-1:0]];

    assign core_valid   = core_valid_q;
    assign core_din     = core_din_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign letter_count = letter_count_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = (state_q != IDLE) || !fifo_empty;

    // FIFO storage. It has no reset, because the pointers decide which entries
    // are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= s_data;
        end
    end

    // Next-state logic for the FIFO pointers and the byte-sequencing FSM.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d       = rd_ptr_q + (AW+1)'(rd_en);
        wait_cnt_d     = wait_cnt_q;
        letter_count_d = letter_count_q;
        timeout_err_d  = timeout_err_q;
        core_valid_d   = 1'b0;
        core_din_d     = core_din_q;
        m_valid_d      = m_valid_q;
        m_data_d       = m_data_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (is_letter(head_byte)) begin
                        core_din_d   = core_letter(head_byte);
                        core_valid_d = 1'b1;
                        state_d      = ISSUE;
                    end else begin
                        m_data_d  = head_byte;
                        m_valid_d = 1'b1;
                        state_d   = OUT;
                    end
                end
            end
            ISSUE: begin
                wait_cnt_d = 16'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    m_data_d  = core_dout;
                    m_valid_d = 1'b1;
                    if (letter_count_q != 16'hFFFF) begin
                        letter_count_d = letter_count_q + 16'd1;
                    end
                    state_d = OUT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    m_data_d      = TIMEOUT_CHAR;
                    m_valid_d     = 1'b1;
                    state_d       = OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset discards the FIFO contents and any byte in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            wait_cnt_q     <= '0;
            letter_count_q <= '0;
            timeout_err_q  <= 1'b0;
            core_valid_q   <= 1'b0;
            core_din_q     <= '0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            wait_cnt_q     <= wait_cnt_d;
            letter_count_q <= letter_count_d;
            timeout_err_q  <= timeout_err_d;
            core_valid_q   <= core_valid_d;
            core_din_q     <= core_din_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
        end
    end

endmodule

// File: tb/tb_enigma_stream_feeder.sv
// Directed testbench for enigma_stream_feeder, with a simple enigma core model.
// The core model replaces each letter L with ((L - 'A' + 23) mod 26) + 'A',
// so 'A' becomes 'X' and 'B' becomes 'Y'.
module tb_enigma_stream_feeder;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        core_valid;
    logic [7:0]  core_din;
    logic        core_done;
    logic [7:0]  core_dout;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        busy;
    logic [15:0] letter_count;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Core model state
    logic        core_stall = 1'b0;
    int          core_lat   = 3;
    int          core_cnt   = 0;
    logic        model_done = 1'b0;
    logic        stray_done = 1'b0;
    logic [7:0]  model_dout = 8'h00;
    logic [7:0]  model_din  = 8'h00;
    int          pulse_count = 0;
    logic [7:0]  din_log[$];

    assign core_done = model_done | stray_done;
    assign core_dout = model_dout;

    enigma_stream_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .core_valid(core_valid), .core_din(core_din),
        .core_done(core_done), .core_dout(core_dout),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .letter_count(letter_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cipher(input logic [7:0] b);
        int v;
        v = ((int'(b) - 65 + 23) % 26) + 65;
        return 8'(v);
    endfunction

    // Expected output of the whole path for one input byte.
    function automatic logic [7:0] expect_out(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) return cipher(b);
`ifdef LOWERCASE_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) return cipher(b - 8'h20);
`endif
        return b;
    endfunction

    // Core model. It samples core_valid halfway through each cycle. It returns
    // core_done core_lat cycles after the request, or never if core_stall is set.
    always @(negedge clk) begin
        if (reset) begin
            core_cnt   = 0;
            model_done = 1'b0;
        end else begin
            model_done = 1'b0;
            if (core_valid) begin
                pulse_count = pulse_count + 1;
                din_log.push_back(core_din);
                model_din = core_din;
                core_cnt  = core_stall ? 0 : core_lat;
            end else if (core_cnt > 0) begin
                core_cnt = core_cnt - 1;
                if (core_cnt == 0) begin
                    model_done = 1'b1;
                    model_dout = cipher(model_din);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pushes one byte. The task starts and ends on a falling edge.
    task automatic applyStimulus(input logic [7:0] b);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) checkOutput("push_accept", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Accepts one output byte and compares it with the expected value.
    task automatic receiveByte(input string tag, input logic [7:0] exp);
        int guard;
        guard   = 0;
        m_ready = 1'b1;
        while (!m_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_valid"}, 32'(m_valid), 32'd1);
        checkOutput(tag, 32'(m_data), 32'(exp));
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic waitCoreValid();
        int guard;
        guard = 0;
        while (!core_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("core_valid_seen", 32'(core_valid), 32'd1);
    endtask

    // Watchdog: stops the run if the bench hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int          exp_letters;
        int          pc;
        int          accepted;
        logic [7:0]  b;
        logic [7:0]  expq[$];

        exp_letters = 0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_core_valid", 32'(core_valid), 32'd0);
        checkOutput("rst_core_din", 32'(core_din), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_letter_count", 32'(letter_count), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // "AB": the core is called twice and the output order is kept
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        receiveByte("ab_first", 8'h58);
        receiveByte("ab_second", 8'h59);
        exp_letters += 2;
        checkOutput("ab_pulses", 32'(pulse_count), 32'd2);
        checkOutput("ab_din0", 32'(din_log[0]), 32'h41);
        checkOutput("ab_din1", 32'(din_log[1]), 32'h42);
        checkOutput("ab_letter_count", 32'(letter_count), 32'(exp_letters));

        // "A B": the space bypasses the core
        applyStimulus(8'h41);
        applyStimulus(8'h20);
        applyStimulus(8'h42);
        receiveByte("asb_first", 8'h58);
        receiveByte("asb_space", 8'h20);
        receiveByte("asb_third", 8'h59);
        exp_letters += 2;
        checkOutput("asb_pulses", 32'(pulse_count), 32'd4);
        checkOutput("asb_letter_count", 32'(letter_count), 32'(exp_letters));

        // Output backpressure: while m_ready is held low, the output must stay
        // stable and no new core request may start
        m_ready = 1'b0;
        applyStimulus(8'h43);
        applyStimulus(8'h44);
        begin
            int guard;
            guard = 0;
            while (!m_valid && guard < 200) begin
                @(negedge clk);
                guard++;
            end
        end
        pc = pulse_count;
        repeat (10) begin
            @(negedge clk);
            checkOutput("hold_stable", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'h5A});
        end
        checkOutput("hold_no_new_core_valid", 32'(pulse_count), 32'(pc));
        checkOutput("hold_busy", 32'(busy), 32'd1);
        receiveByte("hold_c", 8'h5A);
        receiveByte("hold_d", 8'h41);
        exp_letters += 2;

        // FIFO fill while the output is stalled: the first byte is popped,
        // then DEPTH more bytes fill the FIFO and s_ready goes low
        m_ready  = 1'b0;
        accepted = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            b = (i % 3 == 2) ? 8'h2E : 8'(8'h41 + i);
            if (s_ready) begin
                s_valid = 1'b1;
                s_data  = b;
                expq.push_back(expect_out(b));
                if (b != 8'h2E) exp_letters++;
                accepted++;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checkOutput("fill_accepted", 32'(accepted), 32'(DEPTH + 1));
        checkOutput("fill_s_ready_low", 32'(s_ready), 32'd0);
        checkOutput("fill_busy", 32'(busy), 32'd1);
        while (expq.size() > 0) begin
            receiveByte("fill_drain", expq.pop_front());
        end
        checkOutput("fill_s_ready_back", 32'(s_ready), 32'd1);
        checkOutput("fill_letter_count", 32'(letter_count), 32'(exp_letters));

        // core_done arrives in the same cycle that the timeout limit is reached:
        // done wins and no error is flagged
        core_lat = TIMEOUT;
        applyStimulus(8'h47);
        receiveByte("edge_done", 8'h44);
        exp_letters++;
        checkOutput("edge_no_timeout", 32'(timeout_err), 32'd0);
        checkOutput("edge_letter_count", 32'(letter_count), 32'(exp_letters));
        core_lat = 3;

        // The core never answers: timeout after TIMEOUT wait cycles
        core_stall = 1'b1;
        applyStimulus(8'h45);
        waitCoreValid();
        repeat (TIMEOUT) @(negedge clk);
        checkOutput("to_not_yet", 32'(timeout_err), 32'd0);
        @(negedge clk);
        checkOutput("to_err_set", 32'(timeout_err), 32'd1);
        receiveByte("to_qmark", 8'h3F);
        checkOutput("to_letter_count", 32'(letter_count), 32'(exp_letters));
        core_stall = 1'b0;
        applyStimulus(8'h46);
        receiveByte("to_next_byte", 8'h43);
        exp_letters++;
        checkOutput("to_sticky", 32'(timeout_err), 32'd1);

        // Reset while in WAIT, then a stray core_done that must be ignored
        core_stall = 1'b1;
        applyStimulus(8'h48);
        waitCoreValid();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("midrst_letter_count", 32'(letter_count), 32'd0);
        checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        reset       = 1'b0;
        core_stall  = 1'b0;
        exp_letters = 0;
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("stray_m_valid", 32'(m_valid), 32'd0);
        checkOutput("stray_busy", 32'(busy), 32'd0);
        checkOutput("stray_letter_count", 32'(letter_count), 32'd0);

        // Lowercase byte: folded into the core, or passed through unchanged
        pc = pulse_count;
        applyStimulus(8'h61);
`ifdef LOWERCASE_FOLD_EN
        receiveByte("lower_out", 8'h58);
        checkOutput("lower_pulses", 32'(pulse_count), 32'(pc + 1));
        checkOutput("lower_core_din", 32'(din_log[din_log.size() - 1]), 32'h41);
        exp_letters++;
`else
        receiveByte("lower_out", 8'h61);
        checkOutput("lower_pulses", 32'(pulse_count), 32'(pc));
`endif
        checkOutput("lower_letter_count", 32'(letter_count), 32'(exp_letters));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
